i2c_txn_arbiter: RTL and testbench

Transaction-level controller that shares one `i2c_master` between two requesters. It arbitrates round-robin between the requesters and latches a transaction descriptor (7-bit address, direction, length). It then sequences the master's command stream and data streams for the whole transfer: a single write_multiple burst, or a chain of per-byte read commands. Sits between host-side stream sources/sinks (e.g. `stream_gen` channels) and an `i2c_master` instance; slaves remain on the shared open-drain bus.

---
 rtl/i2c_txn_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one i2c_master between two requesters.
// Round-robin grant, latches a descriptor (addr/rd/len) and then sequences
// the master command stream plus the write/read data streams.
// Ports:
//   req_*            descriptor handshake per requester (slice i)
//   wr_t*/rd_t*      host-side byte streams, steered to the granted requester
//   cmd_*            master s_axis_cmd_* (registered)
//   m_t*/s_t*        master s_axis_data_* / m_axis_data_* (combinational)
//   master_busy,
//   missed_ack       master status inputs
//   done/err         per-requester completion pulse and missed-ACK flag
//   grant/active     current or last grant index; high outside IDLE
module i2c_txn_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [13:0] req_addr,
    input  logic [1:0]  req_rd,
    input  logic [15:0] req_len,
    input  logic [15:0] wr_tdata,
    input  logic [1:0]  wr_tvalid,
    output logic [1:0]  wr_tready,
    output logic [7:0]  rd_tdata,
    output logic [1:0]  rd_tvalid,
    input  logic [1:0]  rd_tready,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        master_busy,
    input  logic        missed_ack,
    output logic        grant,
    output logic        active
);

    typedef enum logic [2:0] {
        IDLE, GRANT, WR_CMD, WR_DATA, RD_CMD, RD_DATA, WAIT_IDLE, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        g_q, g_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic        rd_q, rd_d;
    logic        err_r_q, err_r_d;
    logic [1:0]  req_ready_q, req_ready_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [6:0]  cmd_addr_q, cmd_addr_d;
    logic        cmd_start_q, cmd_start_d;
    logic        cmd_read_q, cmd_read_d;
    logic        cmd_wm_q, cmd_wm_d;
    logic        cmd_stop_q, cmd_stop_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        active_q, active_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            g_q         <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            len_q       <= '0;
            rd_q        <= 1'b0;
            err_r_q     <= 1'b0;
            req_ready_q <= '0;
            done_q      <= '0;
            err_q       <= '0;
            cmd_addr_q  <= '0;
            cmd_start_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_wm_q    <= 1'b0;
            cmd_stop_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            err_r_q     <= err_r_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_start_q <= cmd_start_d;
            cmd_read_q  <= cmd_read_d;
            cmd_wm_q    <= cmd_wm_d;
            cmd_stop_q  <= cmd_stop_d;
            cmd_valid_q <= cmd_valid_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        rd_d        = rd_q;
        err_r_d     = err_r_q;
        req_ready_d = '0;
        done_d      = '0;
        err_d       = '0;
        cmd_addr_d  = cmd_addr_q;
        cmd_start_d = cmd_start_q;
        cmd_read_d  = cmd_read_q;
        cmd_wm_d    = cmd_wm_q;
        cmd_stop_d  = cmd_stop_q;
        cmd_valid_d = cmd_valid_q;
        wr_tready   = '0;
        rd_tvalid   = '0;
        rd_tdata    = '0;
        m_tdata     = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        s_tready    = 1'b0;

        // Missed ACKs are sticky for the whole transfer; GRANT clears them.
        if (missed_ack && state_q != IDLE && state_q != GRANT) begin
            err_r_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    if (&req_valid) begin
                        g_d = ~last_q;
                    end else begin
                        g_d = req_valid[1];
                    end
                    req_ready_d[g_d] = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cmd_addr_d  = g_q ? req_addr[13:7] : req_addr[6:0];
                rd_d        = req_rd[g_q];
                len_d       = g_q ? req_len[15:8] : req_len[7:0];
                cnt_d       = '0;
                err_r_d     = 1'b0;
                cmd_valid_d = 1'b1;
                cmd_start_d = 1'b1;
                cmd_read_d  = rd_d;
                cmd_wm_d    = !rd_d;
                cmd_stop_d  = rd_d ? (len_d == 8'd0) : 1'b1;
                state_d     = rd_d ? RD_CMD : WR_CMD;
            end
            WR_CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                m_tdata = g_q ? wr_tdata[15:8] : wr_tdata[7:0];
                m_tvalid = wr_tvalid[g_q];
                wr_tready[g_q] = m_tready;
                m_tlast = (cnt_q == len_q);
                if (m_tvalid && m_tready) begin
                    if (m_tlast) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            RD_CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                rd_tvalid[g_q] = s_tvalid;
                rd_tdata = s_tdata;
                s_tready = rd_tready[g_q];
                if (s_tvalid && s_tready) begin
                    if (cnt_q == len_q) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        // Next per-byte read command; stop on the last one.
                        cnt_d       = cnt_q + 8'd1;
                        cmd_valid_d = 1'b1;
                        cmd_start_d = (cnt_d == 8'd0);
                        cmd_stop_d  = (cnt_d == len_q);
                        state_d     = RD_CMD;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!master_busy) begin
                    done_d[g_q] = 1'b1;
                    err_d[g_q]  = err_r_d;
                    state_d     = DONE;
                end
            end
            DONE: begin
                last_d  = g_q;
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    assign req_ready          = req_ready_q;
    assign done               = done_q;
    assign err                = err_q;
    assign cmd_address        = cmd_addr_q;
    assign cmd_start          = cmd_start_q;
    assign cmd_read           = cmd_read_q;
    assign cmd_write_multiple = cmd_wm_q;
    assign cmd_stop           = cmd_stop_q;
    assign cmd_valid          = cmd_valid_q;
    assign grant              = g_q;
    assign active             = active_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter: emulates the i2c_master and both requesters
// and checks transfers against a transaction-level expectation.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [13:0] req_addr;
    logic [1:0]  req_rd;
    logic [15:0] req_len;
    logic [15:0] wr_tdata;
    logic [1:0]  wr_tvalid;
    logic [1:0]  wr_tready;
    logic [7:0]  rd_tdata;
    logic [1:0]  rd_tvalid;
    logic [1:0]  rd_tready;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [6:0]  cmd_address;
    logic        cmd_start;
    logic        cmd_read;
    logic        cmd_write_multiple;
    logic        cmd_stop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        master_busy;
    logic        missed_ack;
    logic        grant;
    logic        active;

    i2c_txn_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_rd(req_rd), .req_len(req_len),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
        .done(done), .err(err),
        .cmd_address(cmd_address), .cmd_start(cmd_start),
        .cmd_read(cmd_read), .cmd_write_multiple(cmd_write_multiple),
        .cmd_stop(cmd_stop), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .master_busy(master_busy), .missed_ack(missed_ack),
        .grant(grant), .active(active)
    );

    always #5 clk = ~clk;

    logic [42:0] outs;
    assign outs = {req_ready, wr_tready, rd_tdata, rd_tvalid, done, err,
                   cmd_address, cmd_start, cmd_read, cmd_write_multiple,
                   cmd_stop, cmd_valid, m_tdata, m_tvalid, m_tlast,
                   s_tready, grant, active};

    int checks;
    int failures;
    int lg;
    logic [6:0] d_addr [2];
    bit         d_rd   [2];
    int         d_len  [2];
    logic [7:0] d_data [2][256];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input int r, input bit rd, input logic [6:0] addr,
                            input int len);
        d_rd[r] = rd;
        d_addr[r] = addr;
        d_len[r] = len;
        for (int i = 0; i < 256; i++) d_data[r][i] = 8'($urandom);
        if (r == 0) begin
            req_addr[6:0] = addr;
            req_rd[0] = rd;
            req_len[7:0] = 8'(len);
        end else begin
            req_addr[13:7] = addr;
            req_rd[1] = rd;
            req_len[15:8] = 8'(len);
        end
    endtask

    // One complete transfer. mask: requesters raising req_valid now.
    // bp: percent of stalled cycles; inj: inject a missed ACK;
    // stall_at: byte index where data readys drop for 20 cycles;
    // abort_at: byte index where reset is asserted mid-transfer.
    task automatic xfer(input logic [1:0] mask, input int bp, input bit inj,
                        input int stall_at, input int abort_at,
                        input bit chk_lat);
        int g, len, wi, ri, ncmd, ncmd_exp, tail, stall_n, rdy_cyc, cmd_cyc;
        bit rd, got, pend, fin, seen_cmd, ack_nxt, prev_v, prev_busy;
        bit stalled, bdone;
        logic [10:0] prev_f, acc_f, f, ef;
        g = (mask == 2'b11) ? 1 - lg : (mask[1] ? 1 : 0);
        rd = d_rd[g];
        len = d_len[g];
        ncmd_exp = rd ? len + 1 : 1;
        wi = 0; ri = 0; ncmd = 0; stall_n = 0;
        tail = int'($urandom_range(3));
        rdy_cyc = -1; cmd_cyc = -1;
        got = 0; pend = 0; fin = 0; seen_cmd = 0; ack_nxt = 0;
        prev_v = 0; prev_busy = 0; prev_f = '0; acc_f = '0;
        @(negedge clk);
        req_valid = req_valid | mask;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (abort_at >= 0 && wi == abort_at) begin
                rst = 1'b0;
                #1;
                check("reset_outs", 64'(outs), 64'd0);
                lg = 1;
                req_valid = '0;
                return;
            end
            prev_busy = master_busy;
            bdone = rd ? (ri > len) : (wi > len);
            stalled = seen_cmd && stall_at >= 0 && (wi + ri == stall_at)
                      && stall_n < 20;
            if (stalled) stall_n++;
            cmd_ready = ($urandom_range(99) >= bp);
            m_tready = !stalled && ($urandom_range(99) >= bp);
            rd_tready = 2'($urandom);
            rd_tready[g] = !stalled && ($urandom_range(99) >= bp);
            wr_tdata = 16'($urandom);
            wr_tvalid = 2'($urandom);
            wr_tvalid[g] = (wi <= len) && ($urandom_range(99) >= bp);
            if (wi <= len) wr_tdata[g*8 +: 8] = d_data[g][wi];
            s_tvalid = pend && ($urandom_range(99) >= bp);
            s_tdata = pend ? d_data[g][ri] : 8'($urandom);
            master_busy = seen_cmd && !(bdone && tail == 0);
            if (bdone && tail > 0) tail--;
            missed_ack = inj ? ack_nxt : !got;
            ack_nxt = 0;
            #1;
            f = {cmd_address, cmd_start, cmd_read, cmd_write_multiple,
                 cmd_stop};
            check("other_quiet", 64'({rd_tvalid[1-g], wr_tready[1-g]}),
                  64'd0);
            if (!got) begin
                if (req_ready != 2'b00) begin
                    check("req_ready", 64'(req_ready), 64'(2'b01 << g));
                    check("grant", 64'(grant), 64'(g));
                    if (chk_lat) check("ready_lat", 64'(cyc), 64'd1);
                    got = 1;
                    rdy_cyc = cyc;
                    req_valid[g] = 1'b0;
                end
            end else begin
                check("ready_width", 64'(req_ready), 64'd0);
                check("active", 64'(active), 64'd1);
            end
            if (cmd_valid) begin
                if (cmd_cyc < 0) begin
                    cmd_cyc = cyc;
                    if (chk_lat)
                        check("cmd_lat", 64'(cyc - rdy_cyc), 64'd1);
                end
                if (prev_v) check("cmd_hold", 64'(f), 64'(prev_f));
                if (cmd_ready) begin
                    ef = rd ? {d_addr[g], ncmd == 0, 1'b1, 1'b0, ncmd == len}
                            : {d_addr[g], 4'b1011};
                    check("cmd_fields", 64'(f), 64'(ef));
                    check("cmd_count", 64'(ncmd < ncmd_exp), 64'd1);
                    if (rd) check("rd_order", 64'(pend), 64'd0);
                    ncmd++;
                    seen_cmd = 1;
                    acc_f = f;
                    pend = rd;
                    if (ncmd == 1) ack_nxt = 1;
                end
                prev_v = !cmd_ready;
                prev_f = f;
            end else begin
                prev_v = 0;
                if (stalled) check("stall_hold", 64'(f), 64'(acc_f));
            end
            if (m_tvalid && m_tready) begin
                if (wi > len) check("wr_extra", 64'd1, 64'd0);
                else check("wr_data", 64'({m_tlast, m_tdata}),
                           64'({wi == len, d_data[g][wi]}));
                wi++;
            end
            if (pend && s_tvalid)
                check("s_tready", 64'(s_tready), 64'(rd_tready[g]));
            if (s_tvalid && s_tready) begin
                check("rd_data", 64'({rd_tvalid[g], rd_tdata}),
                      64'({1'b1, d_data[g][ri]}));
                ri++;
                pend = 0;
            end
            if (done != 2'b00) begin
                bdone = rd ? (ri > len) : (wi > len);
                check("done_err", 64'({done, err}),
                      64'({2'b01 << g, inj ? 2'b01 << g : 2'b00}));
                check("done_after", 64'({bdone, ncmd == ncmd_exp, prev_busy}),
                      64'(3'b110));
                lg = g;
                fin = 1;
            end
            @(negedge clk);
        end
        if (!fin) check("timeout", 64'd0, 64'd1);
        else check("done_clear", 64'({done, active}), 64'd0);
    endtask

    initial begin
        int m;
        bit inj_r;
        checks = 0;
        failures = 0;
        lg = 1;
        rst = 1'b0;
        req_valid = '0; req_addr = '0; req_rd = '0; req_len = '0;
        wr_tdata = '0; wr_tvalid = '0; rd_tready = '0;
        cmd_ready = 1'b0; m_tready = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0;
        master_busy = 1'b0; missed_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'(outs), 64'd0);
        rst = 1'b1;

        // Both requesters valid from reset: alternate, then drain.
        set_desc(0, 0, 7'h33, 2);
        set_desc(1, 1, 7'h44, 1);
        for (int i = 0; i < 4; i++) xfer(2'b11, 20, 0, -1, -1, 0);
        xfer(2'b01, 20, 0, -1, -1, 0);

        // Write 3 bytes A1,B2,C3 to 0x50.
        set_desc(0, 0, 7'h50, 2);
        d_data[0][0] = 8'hA1; d_data[0][1] = 8'hB2; d_data[0][2] = 8'hC3;
        xfer(2'b01, 0, 0, -1, -1, 1);

        // Read 2 bytes 5E,F0 from 0x2A.
        set_desc(1, 1, 7'h2A, 1);
        d_data[1][0] = 8'h5E; d_data[1][1] = 8'hF0;
        xfer(2'b10, 0, 0, -1, -1, 1);

        // Missed ACK on a single-byte write, then a clean transfer.
        set_desc(0, 0, 7'h11, 0);
        xfer(2'b01, 10, 1, -1, -1, 0);
        set_desc(0, 0, 7'($urandom), 3);
        xfer(2'b01, 10, 0, -1, -1, 0);

        // 20-cycle data backpressure mid-transfer.
        set_desc(1, 0, 7'($urandom), 7);
        xfer(2'b10, 0, 0, 3, -1, 0);
        set_desc(0, 1, 7'($urandom), 5);
        xfer(2'b01, 0, 0, 2, -1, 0);

        // Length boundaries.
        set_desc(0, 0, 7'($urandom), 255);
        xfer(2'b01, 10, 0, -1, -1, 0);
        set_desc(1, 1, 7'($urandom), 255);
        xfer(2'b10, 10, 0, -1, -1, 0);
        set_desc(1, 1, 7'($urandom), 0);
        xfer(2'b10, 10, 0, -1, -1, 0);

        // Randomized transfers.
        for (int i = 0; i < 12; i++) begin
            m = int'($urandom_range(3, 1));
            inj_r = ($urandom_range(3) == 0);
            set_desc(0, 1'($urandom), 7'($urandom), int'($urandom_range(15)));
            set_desc(1, 1'($urandom), 7'($urandom), int'($urandom_range(15)));
            xfer(2'(m), int'($urandom_range(50)), inj_r, -1, -1, 0);
            if (m == 3)
                xfer(2'b01 << (1 - lg), int'($urandom_range(50)), 0,
                     -1, -1, 0);
        end

        // Reset during WR_DATA at byte 2 of 4, with last grant = 0.
        set_desc(0, 0, 7'($urandom), 1);
        xfer(2'b01, 0, 0, -1, -1, 0);
        set_desc(1, 0, 7'($urandom), 3);
        xfer(2'b10, 0, 0, -1, 2, 0);
        @(negedge clk);
        rst = 1'b1;
        set_desc(0, 0, 7'($urandom), 1);
        set_desc(1, 1, 7'($urandom), 1);
        xfer(2'b11, 0, 0, -1, -1, 0);
        xfer(2'b10, 0, 0, -1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
